// File: rtl/qam_symbol_mapper.sv
// Serial-to-parallel M-QAM mapper: packs BITS_PER_SYM bits (first bit = MSB) into
// a symbol and registers signed I/Q levels, sign bits and a symbol count. Gray decode via QAM_GRAY_EN.
module qam_symbol_mapper #(
  parameter int BITS_PER_SYM = 4,
  parameter int CNT_W        = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  input  logic                      flush,
  output logic                      sym_valid,
  output logic [BITS_PER_SYM-1:0]   sym_bits,
  output logic [BITS_PER_SYM/2:0]   i_level,
  output logic [BITS_PER_SYM/2:0]   q_level,
  output logic [1:0]                sign_iq,
  output logic [CNT_W-1:0]          sym_count
);

  localparam int N  = BITS_PER_SYM;
  localparam int H  = BITS_PER_SYM / 2;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);
  localparam logic [H:0]    OFS  = (H+1)'((1 << H) - 1);

  typedef enum logic {FILL, EMIT} state_t;
  state_t state, state_nxt;

  logic [N-2:0]  shreg;
  logic [N-1:0]  word;
  logic [BW-1:0] bcnt;
  logic          last;
  logic [H-1:0]  ki, kq;
  logic [H:0]    lvl_i, lvl_q;

  function automatic logic [H-1:0] to_index(input logic [H-1:0] f);
    logic [H-1:0] b;
`ifdef QAM_GRAY_EN
    b[H-1] = f[H-1];
    for (int unsigned i = 1; i < H; i++)
      b[H-1-i] = b[H-i] ^ f[H-1-i];
`else
    b = f;
`endif
    return b;
  endfunction

  assign word = {shreg, bit_in};
  assign last = bit_valid && !flush && (bcnt == LAST);

  // 2k-(2^H-1) fits H+1 bits exactly, so evaluating it modulo 2^(H+1) loses nothing
  always_comb begin
    ki    = to_index(word[N-1:H]);
    kq    = to_index(word[H-1:0]);
    lvl_i = {ki, 1'b0} - OFS;
    lvl_q = {kq, 1'b0} - OFS;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sym_valid = 1'b0;
    case (state)
      FILL: if (last) state_nxt = EMIT;
      EMIT: begin
        sym_valid = 1'b1;
        state_nxt = last ? EMIT : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bcnt      <= '0;
      sym_bits  <= '0;
      i_level   <= '0;
      q_level   <= '0;
      sign_iq   <= '0;
      sym_count <= '0;
    end else if (flush) begin
      // realign: a coincident bit becomes bit 1 of the new symbol
      shreg <= '0;
      if (bit_valid) shreg[0] <= bit_in;
      bcnt <= bit_valid ? BW'(1) : '0;
    end else if (bit_valid) begin
      shreg <= word[N-2:0];
      if (last) begin
        bcnt      <= '0;
        sym_bits  <= word;
        i_level   <= lvl_i;
        q_level   <= lvl_q;
        sign_iq   <= {~word[N-1], ~word[H-1]};
        sym_count <= sym_count + CNT_W'(1);
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Scoreboard bench for qam_symbol_mapper: N=4 instance for mapping/flush/reset cases,
// N=2/CNT_W=4 instance for back-to-back symbols and counter wrap.
module tb_qam_symbol_mapper;

`ifdef QAM_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic bit_in, bit_valid, flush;
  logic sym_valid;
  logic [3:0] sym_bits;
  logic [2:0] i_level, q_level;
  logic [1:0] sign_iq;
  logic [15:0] sym_count;

  logic bit_in2, bit_valid2, flush2;
  logic sym_valid2;
  logic [1:0] sym_bits2;
  logic [1:0] i_level2, q_level2;
  logic [1:0] sign_iq2;
  logic [3:0] sym_count2;

  qam_symbol_mapper #(.BITS_PER_SYM(4), .CNT_W(16)) dut (
    .clock(clk), .reset(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .sym_valid(sym_valid), .sym_bits(sym_bits), .i_level(i_level), .q_level(q_level),
    .sign_iq(sign_iq), .sym_count(sym_count));

  qam_symbol_mapper #(.BITS_PER_SYM(2), .CNT_W(4)) dut2 (
    .clock(clk), .reset(rst), .bit_in(bit_in2), .bit_valid(bit_valid2), .flush(flush2),
    .sym_valid(sym_valid2), .sym_bits(sym_bits2), .i_level(i_level2), .q_level(q_level2),
    .sign_iq(sign_iq2), .sym_count(sym_count2));

  typedef struct {
    logic [3:0]  bits;
    logic [2:0]  il, ql;
    logic [1:0]  sg;
    logic [15:0] cnt;
    int          cyc;
  } exp4_t;

  typedef struct {
    logic [1:0] bits;
    logic [1:0] il, ql;
    logic [1:0] sg;
    logic [3:0] cnt;
    int         cyc;
  } exp2_t;

  exp4_t q4[$];
  exp2_t q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] l3(input int v);
    logic [31:0] t;
    t = v;
    return t[2:0];
  endfunction

  function automatic logic [1:0] l2(input int v);
    logic [31:0] t;
    t = v;
    return t[1:0];
  endfunction

  // monitors: pop one expectation per presented symbol
  always @(negedge clk) begin
    if (sym_valid) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_sym4: got sym_bits %0h expected no symbol", sym_bits);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        chk("sym4_cycle", cyc, e.cyc);
        chk("sym4_bits", {28'b0, sym_bits}, {28'b0, e.bits});
        chk("sym4_i_level", {29'b0, i_level}, {29'b0, e.il});
        chk("sym4_q_level", {29'b0, q_level}, {29'b0, e.ql});
        chk("sym4_sign_iq", {30'b0, sign_iq}, {30'b0, e.sg});
        chk("sym4_count", {16'b0, sym_count}, {16'b0, e.cnt});
      end
    end
    if (sym_valid2) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_sym2: got sym_bits %0h expected no symbol", sym_bits2);
      end else begin
        exp2_t e;
        e = q2.pop_front();
        chk("sym2_cycle", cyc, e.cyc);
        chk("sym2_bits", {30'b0, sym_bits2}, {30'b0, e.bits});
        chk("sym2_i_level", {30'b0, i_level2}, {30'b0, e.il});
        chk("sym2_q_level", {30'b0, q_level2}, {30'b0, e.ql});
        chk("sym2_sign_iq", {30'b0, sign_iq2}, {30'b0, e.sg});
        chk("sym2_count", {28'b0, sym_count2}, {28'b0, e.cnt});
      end
    end
  end

  // drives one accepted bit; returns #1 after the accepting edge
  task automatic send(input logic b, input logic fl);
    bit_in = b; bit_valid = 1'b1; flush = fl;
    @(posedge clk); #1;
    bit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [3:0] b, input int il, input int ql,
                       input logic [1:0] sg, input logic [15:0] cnt);
    exp4_t e;
    e.bits = b; e.il = l3(il); e.ql = l3(ql); e.sg = sg; e.cnt = cnt; e.cyc = cyc;
    q4.push_back(e);
  endtask

  task automatic check_zero4(input string tag);
    chk({tag, "_valid"}, {31'b0, sym_valid}, 32'd0);
    chk({tag, "_bits"}, {28'b0, sym_bits}, 32'd0);
    chk({tag, "_i"}, {29'b0, i_level}, 32'd0);
    chk({tag, "_q"}, {29'b0, q_level}, 32'd0);
    chk({tag, "_sign"}, {30'b0, sign_iq}, 32'd0);
    chk({tag, "_count"}, {16'b0, sym_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0;
    bit_in2 = 1'b0; bit_valid2 = 1'b0; flush2 = 1'b0;
    idle(10);
    check_zero4("rst_hold");
    chk("rst_hold_count2", {28'b0, sym_count2}, 32'd0);
    rst = 1'b0;
    idle(5);
    check_zero4("rst_idle");

    // 1,0,1,1 back to back
    send(1, 0); send(0, 0); send(1, 0); send(1, 0);
    push4(4'b1011, GRAY ? 3 : 1, GRAY ? 1 : 3, 2'b00, 16'd1);
    idle(4);

    // 0,0,0,1 with bit_valid every third cycle
    send(0, 0); idle(2); send(0, 0); idle(2); send(0, 0); idle(2); send(1, 0);
    push4(4'b0001, -3, -1, 2'b11, 16'd2);
    idle(4);

    // two bits, flush with a bit, then 1,0,0
    send(1, 0); send(0, 0); send(1, 1); send(1, 0); send(0, 0); send(0, 0);
    push4(4'b1100, GRAY ? 1 : 3, -3, 2'b01, 16'd3);
    idle(4);

    // flush on the would-be final bit suppresses the symbol and restarts with that bit
    send(1, 0); send(1, 0); send(1, 0); send(0, 1); send(1, 0); send(1, 0); send(0, 0);
    push4(4'b0110, -1, GRAY ? 3 : 1, 2'b10, 16'd4);
    idle(4);

    // asynchronous reset mid-symbol
    send(1, 0); send(0, 0); send(1, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_count", {16'b0, sym_count}, 32'd0);
    chk("async_rst_bits", {28'b0, sym_bits}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    push4(4'b1111, GRAY ? 1 : 3, GRAY ? 1 : 3, 2'b00, 16'd1);
    idle(4);

    // N=2, continuous 1,0: symbol every second cycle, count wraps after 16
    bit_valid2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      exp2_t e;
      bit_in2 = 1'b1;
      @(posedge clk); #1;
      bit_in2 = 1'b0;
      @(posedge clk); #1;
      e.bits = 2'b10; e.il = l2(1); e.ql = l2(-1); e.sg = 2'b01;
      e.cnt = 4'(k); e.cyc = cyc;
      q2.push_back(e);
    end
    bit_valid2 = 1'b0;
    idle(4);
    chk("wrap_count2", {28'b0, sym_count2}, 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_symbol_mapper.md
# qam_symbol_mapper

Parametrised serial-to-parallel converter and M-QAM constellation mapper. Accepts the serial bit stream from the data generator, one bit per `bit_valid` strobe, which is normally the prescaled clock-enable domain. It assembles `BITS_PER_SYM` bits into a symbol and emits signed I/Q amplitude levels, per-axis sign bits and a symbol strobe to the sin/cos modulator. It generalises the fixed 2-bit serial-to-parallel stage to 4/16/64/256-QAM and adds level mapping, realignment and symbol counting.

## Interface
- `BITS_PER_SYM`, default 4: bits per symbol. Must be even, 2..8. Define H = BITS_PER_SYM/2.
- `CNT_W`, default 16: width of the symbol counter.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is accepted on a clock edge where this is high.
- `flush`  in  1  synchronous realign: discard the partial symbol.
- `sym_valid`  out  1  one-cycle strobe: new symbol on the outputs.
- `sym_bits`  out  BITS_PER_SYM  raw symbol bits. The first-received bit is the MSB.
- `i_level`  out  H+1  signed in-phase amplitude.
- `q_level`  out  H+1  signed quadrature amplitude.
- `sign_iq`  out  2  [1] = I negative, [0] = Q negative.
- `sym_count`  out  CNT_W  number of symbols emitted since reset.

## Operation
- Two-state FSM:
  - FILL: accumulating bits.
  - EMIT: last bit accepted.
  - FILL -> EMIT on the edge that accepts bit number BITS_PER_SYM.
  - EMIT -> FILL unconditionally on the next edge.
- While in EMIT, a `bit_valid` is accepted as bit 1 of the next symbol, so the stream is never stalled.
- Bit counter `bcnt` runs 0..BITS_PER_SYM-1. On each accepted bit:
  - shift register <= {shreg[N-2:0], `bit_in`};
  - `bcnt` increments.
- On the edge accepting the final bit:
  - `bcnt` returns to 0;
  - `sym_bits` <= {shreg[N-2:0], `bit_in`};
  - the level, sign and count outputs are registered on the same edge.
- Field split: I field = `sym_bits`[N-1:H]; Q field = `sym_bits`[H-1:0].
- Level mapping:
  - k = field decoded to an index (see Configuration);
  - level = 2k - (2^H - 1), giving odd values from -(2^H-1) to +(2^H-1);
  - computed in H+2 bits and truncated to H+1 bits, which is lossless.
- `sign_iq` bit = inverted MSB of the field. This equals the level sign in both Gray and binary modes.
- `sym_count` increments by 1 per emitted symbol and wraps from 2^CNT_W-1 to 0.
- All outputs except `sym_valid` hold their value until the next symbol is emitted.
- `flush`:
  - clears `bcnt` and the shift register;
  - leaves the outputs, the FSM output strobe already scheduled, and `sym_count` unchanged.
- `flush` and `bit_valid` in the same cycle: the partial symbol is discarded and `bit_in` is taken as bit 1 of a new symbol.
- `flush` coinciding with the final bit: flush wins and no symbol is emitted.

## Timing
- Reset values: `sym_valid`=0, `sym_bits`=0, `i_level`=0, `q_level`=0, `sign_iq`=2'b00, `sym_count`=0, FSM=FILL, `bcnt`=0.
- 0 is not a legal level; downstream must gate on `sym_valid` or `sym_count`.
- Latency: `sym_valid` is high for exactly the one cycle following the edge that accepts the last bit, and the outputs are valid in that same cycle.
- `bit_valid` may be asserted on every cycle. With BITS_PER_SYM=2 and continuous `bit_valid`, `sym_valid` pulses every 2nd cycle.
- `bit_valid` gaps of any length are tolerated; the partial symbol is retained.
- Reset asserted mid-symbol discards the partial bits immediately (asynchronous).

## Configuration
- `QAM_GRAY_EN` defined: each H-bit field is treated as Gray code and converted to binary, b[i] = XOR of g[H-1:i], before level mapping. Adjacent levels then differ in one bit.
- `QAM_GRAY_EN` undefined: the field is used directly as the natural-binary index k.

## Test plan
- Reset: hold `reset` for 10 cycles -> all outputs 0, no `sym_valid`; release, no stimulus -> outputs stay 0.
- N=4, consecutive bits 1,0,1,1 -> one `sym_valid` pulse one cycle after the 4th bit, `sym_bits`=4'b1011, `sign_iq`=2'b00.
  - With Gray: `i_level`=+3, `q_level`=+1.
  - Without Gray: `i_level`=+1, `q_level`=+3.
- N=4, bits 0,0,0,1 with `bit_valid` high only every 3rd cycle -> single `sym_valid` only after the 4th accepted bit, `i_level`=-3, `q_level`=-1, `sign_iq`=2'b11 (both modes).
- N=4: send 2 bits, then `flush` together with bit 1, then bits 1,0,0 -> `sym_bits`=4'b1100, `q_level`=-3, `sign_iq`=2'b01.
  - With Gray: `i_level`=+1.
  - Without Gray: `i_level`=+3.
- N=4: assert `reset` after 3 bits, release, send 1,1,1,1 -> exactly one symbol, `sym_count`=1, `sym_bits`=4'b1111.
- N=2, CNT_W=4, continuous alternating bits 1,0 -> `sym_valid` every 2nd cycle, `i_level`=+1, `q_level`=-1. After 16 symbols `sym_count` wraps to 0.
